// File: rtl/debounce_multi.sv
// debounce_multi: N-channel input debouncer with independent 4-state FSM per channel.
// Latency: y/rise/fall commit thr+2 enabled samples after a level change (+2 clk with DEBOUNCE_SYNC_EN).
// Flow: en is a sample strobe, no backpressure; optional 2-flop synchroniser under `DEBOUNCE_SYNC_EN.
module debounce_multi #(
  parameter int N  = 4,
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic [CW-1:0] thr,
  input  logic [N-1:0]  din,
  output logic [N-1:0]  y,
  output logic [N-1:0]  rise,
  output logic [N-1:0]  fall
);

  typedef enum logic [1:0] {
    S0 = 2'b00,  // stable 0
    T1 = 2'b01,  // tentative 1
    S1 = 2'b10,  // stable 1
    T0 = 2'b11   // tentative 0
  } state_t;

  // Value the FSMs actually sample
  logic [N-1:0] din_s;

`ifdef DEBOUNCE_SYNC_EN
  logic [N-1:0] sync_a;
  logic [N-1:0] sync_b;

  // Two-flop synchroniser, free-running on every clk so en does not stretch metastability settling
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_a <= '0;
      sync_b <= '0;
    end else begin
      sync_a <= din;
      sync_b <= sync_a;
    end
  end

  assign din_s = sync_b;
`else
  assign din_s = din;
`endif

  for (genvar k = 0; k < N; k++) begin : g_ch
    state_t        st;
    logic [CW-1:0] cnt;

    // Per-channel filter: counter only runs in tentative states and is bounded by thr, so it never wraps
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        st      <= S0;
        cnt     <= '0;
        y[k]    <= 1'b0;
        rise[k] <= 1'b0;
        fall[k] <= 1'b0;
      end else begin
        rise[k] <= 1'b0;
        fall[k] <= 1'b0;
        if (en) begin
          case (st)
            S0: begin
              cnt <= '0;
              if (din_s[k]) st <= T1;
            end
            T1: begin
              if (!din_s[k]) begin
                st  <= S0;
                cnt <= '0;
              end else if (cnt >= thr) begin
                // >= so a threshold lowered below the running count commits at once
                st      <= S1;
                cnt     <= '0;
                y[k]    <= 1'b1;
                rise[k] <= 1'b1;
              end else begin
                cnt <= cnt + 1'b1;
              end
            end
            S1: begin
              cnt <= '0;
              if (!din_s[k]) st <= T0;
            end
            T0: begin
              if (din_s[k]) begin
                st  <= S1;
                cnt <= '0;
              end else if (cnt >= thr) begin
                st      <= S0;
                cnt     <= '0;
                y[k]    <= 1'b0;
                fall[k] <= 1'b1;
              end else begin
                cnt <= cnt + 1'b1;
              end
            end
            default: begin
              st  <= S0;
              cnt <= '0;
            end
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_debounce_multi.sv
// Directed testbench for debounce_multi (default build, N=4, CW=4).
// Inputs change and outputs are sampled 1 time unit after each rising edge.
// Each scenario task carries its own hand-computed expectations.
module tb_debounce_multi;

  localparam int N  = 4;
  localparam int CW = 4;

  logic          clk;
  logic          rst;
  logic          en;
  logic [CW-1:0] thr;
  logic [N-1:0]  din;
  logic [N-1:0]  y;
  logic [N-1:0]  rise;
  logic [N-1:0]  fall;

  int checks = 0;
  int errors = 0;

  debounce_multi #(.N(N), .CW(CW)) dut (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .thr  (thr),
    .din  (din),
    .y    (y),
    .rise (rise),
    .fall (fall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // advance n rising edges, landing 1 unit after the last one
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; thr = 4'd3; din = 4'b1111;
    tick(3);
    checks++; if (y !== 4'b0000) begin errors++; $display("FAIL reset_y got=%b exp=%b", y, 4'b0000); end
    checks++; if (rise !== 4'b0000) begin errors++; $display("FAIL reset_rise got=%b exp=%b", rise, 4'b0000); end
    checks++; if (fall !== 4'b0000) begin errors++; $display("FAIL reset_fall got=%b exp=%b", fall, 4'b0000); end
    din = 4'b0000;
    rst = 1'b0;
    tick(2);
  endtask

  task automatic test_commit();
    thr = 4'd3; en = 1'b1;
    din = 4'b0001;
    tick(4);  // edges 0..3: still tentative
    checks++; if (y !== 4'b0000) begin errors++; $display("FAIL commit_pre_y got=%b exp=%b", y, 4'b0000); end
    tick(1);  // edge 4 commits
    checks++; if (y !== 4'b0001) begin errors++; $display("FAIL commit_y got=%b exp=%b", y, 4'b0001); end
    checks++; if (rise !== 4'b0001) begin errors++; $display("FAIL commit_rise got=%b exp=%b", rise, 4'b0001); end
    tick(1);
    checks++; if (rise !== 4'b0000) begin errors++; $display("FAIL commit_rise_clear got=%b exp=%b", rise, 4'b0000); end
    checks++; if (y !== 4'b0001) begin errors++; $display("FAIL commit_hold_y got=%b exp=%b", y, 4'b0001); end
    din = 4'b0000;
    tick(4);
    checks++; if (y !== 4'b0001) begin errors++; $display("FAIL release_pre_y got=%b exp=%b", y, 4'b0001); end
    tick(1);
    checks++; if (y !== 4'b0000) begin errors++; $display("FAIL release_y got=%b exp=%b", y, 4'b0000); end
    checks++; if (fall !== 4'b0001) begin errors++; $display("FAIL release_fall got=%b exp=%b", fall, 4'b0001); end
    tick(1);
    checks++; if (fall !== 4'b0000) begin errors++; $display("FAIL release_fall_clear got=%b exp=%b", fall, 4'b0000); end
  endtask

  task automatic test_abort();
    thr = 4'd3; en = 1'b1;
    din = 4'b0010;
    for (int i = 0; i < 4; i++) begin
      tick(1);
      checks++; if ({y, rise, fall} !== 12'b0) begin errors++; $display("FAIL abort_run%0d got y=%b rise=%b fall=%b exp all 0", i, y, rise, fall); end
    end
    din = 4'b0000;  // fifth sample is 0 -> abort
    for (int i = 0; i < 3; i++) begin
      tick(1);
      checks++; if ({y, rise, fall} !== 12'b0) begin errors++; $display("FAIL abort_after%0d got y=%b rise=%b fall=%b exp all 0", i, y, rise, fall); end
    end
    // from S0 again, a full 5-sample run commits
    din = 4'b0010;
    tick(4);
    checks++; if (y !== 4'b0000) begin errors++; $display("FAIL abort_retry_pre got=%b exp=%b", y, 4'b0000); end
    tick(1);
    checks++; if (y !== 4'b0010) begin errors++; $display("FAIL abort_retry_y got=%b exp=%b", y, 4'b0010); end
    checks++; if (rise !== 4'b0010) begin errors++; $display("FAIL abort_retry_rise got=%b exp=%b", rise, 4'b0010); end
    din = 4'b0000;
    tick(6);
    checks++; if (y !== 4'b0000) begin errors++; $display("FAIL abort_cleanup got=%b exp=%b", y, 4'b0000); end
  endtask

  task automatic test_enable();
    int ens;
    logic [N-1:0] exp_y;
    logic [N-1:0] exp_rise;
    ens = 0;
    thr = 4'd3;
    din = 4'b0100;
    for (int i = 0; i < 12; i++) begin
      en = (i % 2 == 0);
      tick(1);
      if (en) ens++;
      exp_y    = (ens >= 5) ? 4'b0100 : 4'b0000;
      exp_rise = (en && ens == 5) ? 4'b0100 : 4'b0000;
      checks++; if (y !== exp_y) begin errors++; $display("FAIL enable_y cyc%0d got=%b exp=%b", i, y, exp_y); end
      checks++; if (rise !== exp_rise) begin errors++; $display("FAIL enable_rise cyc%0d got=%b exp=%b", i, rise, exp_rise); end
    end
    en = 1'b1;
    din = 4'b0000;
    tick(6);
    checks++; if (y !== 4'b0000) begin errors++; $display("FAIL enable_cleanup got=%b exp=%b", y, 4'b0000); end
  endtask

  task automatic test_thr_change();
    en = 1'b1;
    thr = 4'd9;
    din = 4'b1000;
    tick(6);  // edge 0 enters T1, edges 1..5 count to 5
    checks++; if (y !== 4'b0000) begin errors++; $display("FAIL thr_pre got=%b exp=%b", y, 4'b0000); end
    thr = 4'd2;
    tick(1);
    checks++; if (y !== 4'b1000) begin errors++; $display("FAIL thr_lower_y got=%b exp=%b", y, 4'b1000); end
    checks++; if (rise !== 4'b1000) begin errors++; $display("FAIL thr_lower_rise got=%b exp=%b", rise, 4'b1000); end
    thr = 4'd0;
    din = 4'b0000;
    tick(1);
    checks++; if (y !== 4'b1000) begin errors++; $display("FAIL thr0_first got=%b exp=%b", y, 4'b1000); end
    tick(1);
    checks++; if (y !== 4'b0000) begin errors++; $display("FAIL thr0_y got=%b exp=%b", y, 4'b0000); end
    checks++; if (fall !== 4'b1000) begin errors++; $display("FAIL thr0_fall got=%b exp=%b", fall, 4'b1000); end
    tick(1);
  endtask

  task automatic test_async_reset();
    en = 1'b1;
    thr = 4'd3;
    din = 4'b0010;
    tick(5);
    checks++; if (y !== 4'b0010) begin errors++; $display("FAIL arst_setup got=%b exp=%b", y, 4'b0010); end
    tick(1);
    din = 4'b0011;
    tick(3);  // channel 0 in T1 with cnt=2
    #2 rst = 1'b1;
    #1;
    checks++; if (y !== 4'b0000) begin errors++; $display("FAIL arst_y got=%b exp=%b", y, 4'b0000); end
    checks++; if ({rise, fall} !== 8'b0) begin errors++; $display("FAIL arst_pulse got rise=%b fall=%b exp 0", rise, fall); end
    #2 rst = 1'b0;
    tick(4);
    checks++; if (y !== 4'b0000) begin errors++; $display("FAIL arst_relearn_pre got=%b exp=%b", y, 4'b0000); end
    tick(1);
    checks++; if (y !== 4'b0011) begin errors++; $display("FAIL arst_relearn_y got=%b exp=%b", y, 4'b0011); end
    checks++; if (rise !== 4'b0011) begin errors++; $display("FAIL arst_relearn_rise got=%b exp=%b", rise, 4'b0011); end
    din = 4'b0000;
    tick(5);
    checks++; if (fall !== 4'b0011) begin errors++; $display("FAIL multi_fall got=%b exp=%b", fall, 4'b0011); end
    checks++; if (y !== 4'b0000) begin errors++; $display("FAIL multi_fall_y got=%b exp=%b", y, 4'b0000); end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; thr = '0; din = '0;
    #1;
    test_reset();
    test_commit();
    test_abort();
    test_enable();
    test_thr_change();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
